// File: rtl/prog_delay_line_pkg.sv
// Shared sizing helpers for the programmable delay line and its ring buffer.
package prog_delay_line_pkg;

  // Index width for a memory of `depth` entries; never collapses to zero bits.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prog_delay_line_ring_buffer.sv
// Circular store of {valid, data} entries with a write pointer and a
// read index that trails it by a run-time offset (any depth, not just 2^n).
module dl_ring_buffer
  import prog_delay_line_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int OW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              clr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  input  logic [OW-1:0]     rd_offset,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int AW = idx_w(DEPTH);
  localparam int EW = max_i(AW, OW) + 1;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]  mem_vld;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rd_idx;
  logic [EW-1:0]     wp_e;
  logic [EW-1:0]     off_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
      end
      mem_vld <= '0;
      wptr    <= '0;
    end else if (ce) begin
      mem_data[wptr] <= wr_data;
      if (clr_valid) begin
        mem_vld <= '0;
      end
      // Later assignment wins, so the freshly written bit obeys the clear too.
      mem_vld[wptr] <= wr_valid & ~clr_valid;
      wptr          <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
    end
  end

  // Offset == DEPTH lands on wptr itself: the oldest entry, read before overwrite.
  always_comb begin
    wp_e  = EW'(wptr);
    off_e = EW'(rd_offset);
    if (wp_e >= off_e) begin
      rd_idx = AW'(wp_e - off_e);
    end else begin
      rd_idx = AW'(wp_e + EW'(DEPTH) - off_e);
    end
  end

  assign rd_data  = mem_data[rd_idx];
  assign rd_valid = mem_vld[rd_idx];

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel delay line with run-time delay, clamping, fill tracking so
// stale samples are never flagged valid, and a zero-delay bypass.
module prog_delay_line
  import prog_delay_line_pkg::*;
#(
  parameter  int CHANNELS  = 3,
  parameter  int WIDTH     = 8,
  parameter  int MAX_DELAY = 16,
  localparam int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      flush,
  input  logic [DW-1:0]             delay,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [DW-1:0]             delay_act
);

  localparam int BW = CHANNELS * WIDTH;

  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
    return (d > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : d;
  endfunction

  logic [DW-1:0] delay_clamp;
  logic [DW-1:0] fill;
  logic [BW-1:0] rd_data;
  logic          rd_valid;
  logic          bypass;
  logic          ring_ok;

  assign delay_clamp = clamp_delay(delay);

  // fill counts ce edges since the last delay change or flush; the ring only
  // holds a coherent history once it reaches the active delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay_act <= '0;
      fill      <= '0;
    end else if (ce) begin
      delay_act <= delay_clamp;
      if (flush || (delay_clamp != delay_act)) begin
        fill <= '0;
      end else if (fill < DW'(MAX_DELAY)) begin
        fill <= fill + 1'b1;
      end
    end
  end

  dl_ring_buffer #(
    .DEPTH  (MAX_DELAY),
    .DATA_W (BW),
    .OW     (DW)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .clr_valid (flush),
    .wr_data   (in),
    .wr_valid  (in_valid),
    .rd_offset (delay_act),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  assign bypass  = (delay_act == '0);
  assign ring_ok = rd_valid && (fill >= delay_act);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    always_comb begin
      out[k*WIDTH +: WIDTH] = '0;
      if (rst) begin
        out[k*WIDTH +: WIDTH] = bypass ? in[k*WIDTH +: WIDTH] : rd_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Outputs are held at zero while reset is asserted, even in bypass.
  always_comb begin
    out_valid = 1'b0;
    if (rst) begin
      out_valid = bypass ? in_valid : ring_ok;
    end
  end

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench: vector table for the streaming cases, hand sequences for
// clamping/wrap, ce gating against a register-chain model, and async reset.
module tb_prog_delay_line;

  localparam int CHANNELS  = 3;
  localparam int WIDTH     = 8;
  localparam int MAX_DELAY = 16;
  localparam int DW        = $clog2(MAX_DELAY + 1);
  localparam int BW        = CHANNELS * WIDTH;
  localparam int NV        = 42;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          flush;
  logic [DW-1:0] delay;
  logic          in_valid;
  logic [BW-1:0] din;
  logic          out_valid;
  logic [BW-1:0] dout;
  logic [DW-1:0] delay_act;

  always #5 clk = ~clk;

  prog_delay_line #(
    .CHANNELS  (CHANNELS),
    .WIDTH     (WIDTH),
    .MAX_DELAY (MAX_DELAY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .flush     (flush),
    .delay     (delay),
    .in_valid  (in_valid),
    .in        (din),
    .out_valid (out_valid),
    .out       (dout),
    .delay_act (delay_act)
  );

  typedef struct {
    logic          fl;
    logic [DW-1:0] dly;
    logic          iv;
    logic [BW-1:0] din;
    logic          ev;
    logic [BW-1:0] eout;
    logic [DW-1:0] eda;
  } vec_t;

  vec_t tv [NV];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic setv(input int c, input int d, input logic ev, input int eo, input int eda);
    tv[c].dly  = DW'(d);
    tv[c].ev   = ev;
    tv[c].eout = BW'(eo);
    tv[c].eda  = DW'(eda);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] pat(input int k);
    if (k == 1) return 24'hABCDEF;
    return {8'(k), 8'(k + 64), 8'(k + 128)};
  endfunction

  logic [BW-1:0] r1, r2;
  logic          v1, v2;
  int            ce_pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    for (int c = 0; c < NV; c++) begin
      tv[c].fl  = 1'b0;
      tv[c].iv  = 1'b1;
      tv[c].din = BW'(c + 1);
    end
    tv[26].fl = 1'b1;
    tv[33].iv = 1'b0;
    tv[35].iv = 1'b0;
    // delay=3 ramp, then 4, then 2, then 5 with flush at 26 and holes at 33/35
    setv( 0, 3, 1,  1, 0); setv( 1, 3, 0,  0, 3); setv( 2, 3, 0,  0, 3);
    setv( 3, 3, 0,  1, 3); setv( 4, 3, 1,  2, 3); setv( 5, 3, 1,  3, 3);
    setv( 6, 3, 1,  4, 3); setv( 7, 3, 1,  5, 3); setv( 8, 4, 1,  6, 3);
    setv( 9, 4, 0,  6, 4); setv(10, 4, 0,  7, 4); setv(11, 4, 0,  8, 4);
    setv(12, 4, 0,  9, 4); setv(13, 4, 1, 10, 4); setv(14, 2, 1, 11, 4);
    setv(15, 2, 0, 14, 2); setv(16, 2, 0, 15, 2); setv(17, 2, 1, 16, 2);
    setv(18, 2, 1, 17, 2); setv(19, 5, 1, 18, 2); setv(20, 5, 0, 16, 5);
    setv(21, 5, 0, 17, 5); setv(22, 5, 0, 18, 5); setv(23, 5, 0, 19, 5);
    setv(24, 5, 0, 20, 5); setv(25, 5, 1, 21, 5); setv(26, 5, 1, 22, 5);
    setv(27, 5, 0, 23, 5); setv(28, 5, 0, 24, 5); setv(29, 5, 0, 25, 5);
    setv(30, 5, 0, 26, 5); setv(31, 5, 0, 27, 5); setv(32, 5, 1, 28, 5);
    setv(33, 5, 1, 29, 5); setv(34, 5, 1, 30, 5); setv(35, 5, 1, 31, 5);
    setv(36, 5, 1, 32, 5); setv(37, 5, 1, 33, 5); setv(38, 5, 0, 34, 5);
    setv(39, 5, 1, 35, 5); setv(40, 5, 0, 36, 5); setv(41, 5, 1, 37, 5);

    rst = 1'b0; ce = 1'b1; flush = 1'b0; delay = DW'(3);
    in_valid = 1'b1; din = 24'h123456;
    #2;
    chk("reset out", 32'(dout), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset delay_act", 32'(delay_act), 0);
    tick();
    rst = 1'b1;

    for (int c = 0; c < NV; c++) begin
      ce = 1'b1; flush = tv[c].fl; delay = tv[c].dly;
      in_valid = tv[c].iv; din = tv[c].din;
      @(negedge clk);
      chk($sformatf("tbl%0d out_valid", c), 32'(out_valid), 32'(tv[c].ev));
      chk($sformatf("tbl%0d out", c), 32'(dout), 32'(tv[c].eout));
      chk($sformatf("tbl%0d delay_act", c), 32'(delay_act), 32'(tv[c].eda));
      tick();
    end
    flush = 1'b0;

    // clamp 20 -> 16, ABCDEF after 16 edges, run across pointer wrap
    for (int k = 0; k < 42; k++) begin
      delay = DW'(20); in_valid = 1'b1; din = pat(k);
      @(negedge clk);
      if (k == 1) chk("clamp delay_act", 32'(delay_act), 16);
      if (k == 16) chk("clamp fill edge", 32'(out_valid), 0);
      if (k >= 17) begin
        chk($sformatf("wrap%0d out_valid", k), 32'(out_valid), 1);
        chk($sformatf("wrap%0d out", k), 32'(dout), 32'(pat(k - 16)));
      end
      tick();
    end

    // ce gating versus a 2-stage ce-gated register chain
    for (int j = 0; j < 3; j++) begin
      ce = 1'b1; delay = DW'(2); in_valid = 1'b1; din = 24'h100000 + BW'(j);
      tick();
      r2 = r1; v2 = v1; r1 = din; v1 = in_valid;
    end
    for (int j = 0; j < 9; j++) begin
      ce = (j < 7) ? 1'(ce_pat[j]) : 1'b1;
      in_valid = (j != 3);
      din = 24'h200000 + BW'(j * 24'h111);
      @(negedge clk);
      chk($sformatf("ce%0d out_valid", j), 32'(out_valid), 32'(v2));
      chk($sformatf("ce%0d out", j), 32'(dout), 32'(r2));
      tick();
      if (ce) begin
        r2 = r1; v2 = v1; r1 = din; v1 = in_valid;
      end
    end

    // asynchronous reset mid-stream
    ce = 1'b1; delay = DW'(2); in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      din = 24'h300000 + BW'(j);
      tick();
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async rst out", 32'(dout), 0);
    chk("async rst out_valid", 32'(out_valid), 0);
    chk("async rst delay_act", 32'(delay_act), 0);
    tick();
    chk("held rst out_valid", 32'(out_valid), 0);
    delay = '0; din = 24'h5A5A5A; in_valid = 1'b1; rst = 1'b1;
    #1;
    chk("bypass out", 32'(dout), 32'h5A5A5A);
    chk("bypass out_valid", 32'(out_valid), 1);
    tick();
    din = 24'hA5A5A5; in_valid = 1'b0;
    #1;
    chk("bypass2 out", 32'(dout), 32'hA5A5A5);
    chk("bypass2 out_valid", 32'(out_valid), 0);
    chk("bypass2 delay_act", 32'(delay_act), 0);
    delay = DW'(1); din = 24'h777777; in_valid = 1'b1;
    tick();
    din = 24'h888888;
    #1;
    chk("post rst d1 out_valid", 32'(out_valid), 0);
    chk("post rst d1 delay_act", 32'(delay_act), 1);
    tick();
    din = 24'h999999;
    #1;
    chk("post rst d1 valid", 32'(out_valid), 1);
    chk("post rst d1 out", 32'(dout), 32'h888888);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
